// File: rtl/video_timing_gen.sv
// Programmable video timing generator: H/V sync, data enable and a coordinate
// test pattern, with timing parameters shadowed once per frame.
module video_timing_gen #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic [5:0]    i_VSW,
    input  logic [5:0]    i_VBP,
    input  logic [5:0]    i_VACT,
    input  logic [5:0]    i_VFP,
    input  logic [5:0]    i_HSW,
    input  logic [5:0]    i_HBP,
    input  logic [5:0]    i_HACT,
    input  logic [5:0]    i_HFP,
    output logic          o_vsync,
    output logic          o_hsync,
    output logic          o_de,
    output logic [DW-1:0] o_r,
    output logic [DW-1:0] o_g,
    output logic [DW-1:0] o_b,
    output logic [8:0]    o_hcnt,
    output logic [8:0]    o_vcnt,
    output logic          o_frame_done,
    output logic          o_cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [8:0]    hCnt_q, hCnt_d, vCnt_q, vCnt_d;
    logic [3:0]    frameCnt_q, frameCnt_d;
    logic [5:0]    hSw_q, hBp_q, hAct_q, hFp_q, vSw_q, vBp_q, vAct_q, vFp_q;
    logic          loadShadow, cfgErr_d, frameDone_d;
    logic          hsync_d, vsync_d, de_d, active;
    logic [DW-1:0] r_d, g_d, b_d;
    logic [8:0]    hcntOut_d, vcntOut_d;
    logic [8:0]    hTot, hWaitTh, hActiveTh, vTot, vWaitTh, vActiveTh;
    logic          cfgValid, lastPixel;
    logic [5:0]    px, ln;

    assign hWaitTh   = 9'(hSw_q) + 9'(hBp_q);
    assign hActiveTh = hWaitTh + 9'(hAct_q);
    assign hTot      = hActiveTh + 9'(hFp_q);
    assign vWaitTh   = 9'(vSw_q) + 9'(vBp_q);
    assign vActiveTh = vWaitTh + 9'(vAct_q);
    assign vTot      = vActiveTh + 9'(vFp_q);

    // A frame cannot start without a sync pulse and at least one active pixel/line.
    assign cfgValid  = (i_HSW != 6'd0) && (i_HACT != 6'd0) && (i_VSW != 6'd0) && (i_VACT != 6'd0);
    assign lastPixel = (hCnt_q == hTot) && (vCnt_q == vTot);

    // State register, counters, shadows and the single output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hCnt_q       <= 9'd1;
            vCnt_q       <= 9'd1;
            frameCnt_q   <= 4'd0;
            hSw_q        <= '0;
            hBp_q        <= '0;
            hAct_q       <= '0;
            hFp_q        <= '0;
            vSw_q        <= '0;
            vBp_q        <= '0;
            vAct_q       <= '0;
            vFp_q        <= '0;
            o_vsync      <= 1'b0;
            o_hsync      <= 1'b0;
            o_de         <= 1'b0;
            o_r          <= '0;
            o_g          <= '0;
            o_b          <= '0;
            o_hcnt       <= '0;
            o_vcnt       <= '0;
            o_frame_done <= 1'b0;
            o_cfg_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            frameCnt_q   <= frameCnt_d;
            if (loadShadow) begin
                hSw_q  <= i_HSW;
                hBp_q  <= i_HBP;
                hAct_q <= i_HACT;
                hFp_q  <= i_HFP;
                vSw_q  <= i_VSW;
                vBp_q  <= i_VBP;
                vAct_q <= i_VACT;
                vFp_q  <= i_VFP;
            end
            o_vsync      <= vsync_d;
            o_hsync      <= hsync_d;
            o_de         <= de_d;
            o_r          <= r_d;
            o_g          <= g_d;
            o_b          <= b_d;
            o_hcnt       <= hcntOut_d;
            o_vcnt       <= vcntOut_d;
            o_frame_done <= frameDone_d;
            o_cfg_err    <= cfgErr_d;
        end
    end

    // Next state: DRAIN finishes the current frame but never starts another.
    always_comb begin
        state_d     = state_q;
        hCnt_d      = hCnt_q;
        vCnt_d      = vCnt_q;
        frameCnt_d  = frameCnt_q;
        loadShadow  = 1'b0;
        cfgErr_d    = 1'b0;
        frameDone_d = 1'b0;
        case (state_q)
            IDLE: begin
                hCnt_d = 9'd1;
                vCnt_d = 9'd1;
                if (i_en) begin
                    if (cfgValid) begin
                        loadShadow = 1'b1;
                        state_d    = RUN;
                    end else begin
                        cfgErr_d = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                if (hCnt_q == hTot) begin
                    hCnt_d = 9'd1;
                    if (vCnt_q == vTot) begin
                        vCnt_d      = 9'd1;
                        frameDone_d = 1'b1;
                        frameCnt_d  = frameCnt_q + 4'd1;
                        if (state_q == RUN && i_en) begin
                            if (cfgValid) begin
                                loadShadow = 1'b1;
                            end else begin
                                cfgErr_d = 1'b1;
                                state_d  = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        vCnt_d = vCnt_q + 9'd1;
                    end
                end else begin
                    hCnt_d = hCnt_q + 9'd1;
                end
                if (state_q == RUN && !i_en && !lastPixel) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current counters; registered above for equal latency.
    always_comb begin
        active    = (state_q != IDLE);
        px        = hCnt_q[5:0] - hWaitTh[5:0] - 6'd1;
        ln        = vCnt_q[5:0] - vWaitTh[5:0] - 6'd1;
        hsync_d   = active && (hCnt_q <= 9'(hSw_q));
        vsync_d   = active && (vCnt_q <= 9'(vSw_q));
        de_d      = active && (hCnt_q > hWaitTh) && (hCnt_q <= hActiveTh)
                           && (vCnt_q > vWaitTh) && (vCnt_q <= vActiveTh);
        hcntOut_d = active ? hCnt_q : 9'd0;
        vcntOut_d = active ? vCnt_q : 9'd0;
        r_d       = '0;
        g_d       = '0;
        b_d       = '0;
        if (de_d) begin
            r_d = DW'({px, {DW{1'b0}}} >> 6);
            g_d = DW'({ln, {DW{1'b0}}} >> 6);
            b_d = DW'({frameCnt_q, {DW{1'b0}}} >> 4);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: a frame-level pixel-index model
// checked every cycle, plus hand-computed pins on a reference configuration.
module tb_video_timing_gen;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset, i_en;
    logic [5:0]    i_VSW, i_VBP, i_VACT, i_VFP, i_HSW, i_HBP, i_HACT, i_HFP;
    logic          o_vsync, o_hsync, o_de, o_frame_done, o_cfg_err;
    logic [DW-1:0] o_r, o_g, o_b;
    logic [8:0]    o_hcnt, o_vcnt;

    video_timing_gen #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .i_en(i_en),
        .i_VSW(i_VSW), .i_VBP(i_VBP), .i_VACT(i_VACT), .i_VFP(i_VFP),
        .i_HSW(i_HSW), .i_HBP(i_HBP), .i_HACT(i_HACT), .i_HFP(i_HFP),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_hcnt(o_hcnt), .o_vcnt(o_vcnt),
        .o_frame_done(o_frame_done), .o_cfg_err(o_cfg_err)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cycleNo = 0;
    bit checkEn = 1'b0;

    // Model: running flag, drain flag, linear pixel index inside the frame.
    bit mRun = 1'b0, mDrain = 1'b0;
    int mP = 0, mFc = 0;
    int sh[8];
    bit eHs, eVs, eDe, eFd, eCe;
    int eH, eV, eR, eG, eB;

    int hsCnt, vsCnt, deCnt, ceCnt;
    int fdQ[$], rowR[$], rowG[$], rowH[$], bQ[$];

    task automatic setCfg(input int hsw, hbp, hact, hfp, vsw, vbp, vact, vfp);
        i_HSW = 6'(hsw); i_HBP = 6'(hbp); i_HACT = 6'(hact); i_HFP = 6'(hfp);
        i_VSW = 6'(vsw); i_VBP = 6'(vbp); i_VACT = 6'(vact); i_VFP = 6'(vfp);
    endtask

    task automatic clearTally();
        hsCnt = 0; vsCnt = 0; deCnt = 0; ceCnt = 0;
        fdQ.delete(); rowR.delete(); rowG.delete(); rowH.delete();
    endtask

    // Expected outputs after the coming edge come from the state before it;
    // the error pulse reflects the decision taken at that edge.
    task automatic modelStep();
        int ht, vt, hw, vw, h, v;
        bit last, valid;
        eHs = 0; eVs = 0; eDe = 0; eFd = 0; eCe = 0;
        eH = 0; eV = 0; eR = 0; eG = 0; eB = 0;
        last = 0;
        if (reset) begin
            mRun = 0; mDrain = 0; mFc = 0; mP = 0;
            foreach (sh[k]) sh[k] = 0;
            return;
        end
        if (mRun) begin
            ht = sh[0] + sh[1] + sh[2] + sh[3];
            vt = sh[4] + sh[5] + sh[6] + sh[7];
            hw = sh[0] + sh[1];
            vw = sh[4] + sh[5];
            h = mP % ht + 1;
            v = mP / ht + 1;
            eH = h; eV = v;
            eHs = (h <= sh[0]);
            eVs = (v <= sh[4]);
            eDe = (h > hw) && (h <= hw + sh[2]) && (v > vw) && (v <= vw + sh[6]);
            if (eDe) begin
                eR = ((h - hw - 1) % 64) << (DW - 6);
                eG = ((v - vw - 1) % 64) << (DW - 6);
                eB = mFc << (DW - 4);
            end
            last = (mP == ht * vt - 1);
            eFd = last;
        end
        valid = (i_HSW != 0) && (i_HACT != 0) && (i_VSW != 0) && (i_VACT != 0);
        if (!mRun || last) begin
            if (last) mFc = (mFc + 1) % 16;
            if (i_en && !(mRun && mDrain)) begin
                if (valid) begin
                    sh[0] = i_HSW; sh[1] = i_HBP; sh[2] = i_HACT; sh[3] = i_HFP;
                    sh[4] = i_VSW; sh[5] = i_VBP; sh[6] = i_VACT; sh[7] = i_VFP;
                    mRun = 1; mDrain = 0; mP = 0;
                end else begin
                    eCe = 1; mRun = 0;
                end
            end else begin
                mRun = 0;
            end
        end else begin
            mP++;
            if (!i_en) mDrain = 1;
        end
    endtask

    task automatic checkOutput();
        bit bad;
        vectors++;
        bad = (o_hsync !== eHs) || (o_vsync !== eVs) || (o_de !== eDe) ||
              (o_frame_done !== eFd) || (o_cfg_err !== eCe) ||
              (o_hcnt !== 9'(eH)) || (o_vcnt !== 9'(eV)) ||
              (o_r !== DW'(eR)) || (o_g !== DW'(eG)) || (o_b !== DW'(eB));
        if (bad) begin
            miscompares++;
            if (miscompares <= 30)
                $display("[TB] FAIL outputs cycle=%0d got hs=%b vs=%b de=%b fd=%b ce=%b h=%0d v=%0d r=%0d g=%0d b=%0d expected hs=%b vs=%b de=%b fd=%b ce=%b h=%0d v=%0d r=%0d g=%0d b=%0d",
                         cycleNo, o_hsync, o_vsync, o_de, o_frame_done, o_cfg_err, o_hcnt, o_vcnt, o_r, o_g, o_b,
                         eHs, eVs, eDe, eFd, eCe, eH, eV, eR, eG, eB);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then tally what the DUT shows.
    task automatic applyStimulus(input bit rst, input bit en);
        @(negedge clk);
        reset = rst;
        i_en  = en;
        modelStep();
        checkEn = 1'b1;
        @(posedge clk);
        #2;
        cycleNo++;
        hsCnt += int'(o_hsync);
        vsCnt += int'(o_vsync);
        deCnt += int'(o_de);
        ceCnt += int'(o_cfg_err);
        if (o_frame_done) fdQ.push_back(cycleNo);
        if (o_de && o_vcnt == 9'd4 && (o_hcnt == 9'd6 || rowR.size() != 0) && rowR.size() < 4) begin
            rowR.push_back(int'(o_r));
            rowG.push_back(int'(o_g));
            rowH.push_back(int'(o_hcnt));
        end
        if (o_de && o_hcnt == 9'd6 && o_vcnt == 9'd3) bQ.push_back(int'(o_b));
    endtask

    task automatic randomCfg();
        setCfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
               $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (checkEn) checkOutput();
    end

    initial begin
        int hAfter, vAfter, fdV, fdH, k;
        bit prevFd, gotAfter, en;
        reset = 1'b1;
        i_en  = 1'b0;
        setCfg(2, 3, 4, 1, 1, 1, 2, 1);

        repeat (3) applyStimulus(1, 1);
        checkValue("reset_hcnt", int'(o_hcnt), 0);
        checkValue("reset_hsync", int'(o_hsync), 0);

        // Reference config: HTOT=10, VTOT=5, 50 clocks per frame.
        bQ.delete();
        repeat (20) applyStimulus(0, 1);
        clearTally();
        repeat (100) applyStimulus(0, 1);
        checkValue("hsync_per_2frames", hsCnt, 20);
        checkValue("de_per_2frames", deCnt, 16);
        checkValue("fd_per_2frames", fdQ.size(), 2);
        checkValue("fd_period", (fdQ.size() >= 2) ? fdQ[1] - fdQ[0] : -1, 50);
        checkValue("row4_len", rowR.size(), 4);
        for (int i = 0; i < 4 && i < rowR.size(); i++) begin
            checkValue($sformatf("row4_r%0d", i), rowR[i], i * 16);
            checkValue($sformatf("row4_g%0d", i), rowG[i], 16);
            checkValue($sformatf("row4_h%0d", i), rowH[i], 6 + i);
        end
        repeat (800) applyStimulus(0, 1);
        checkValue("b_frames_seen", int'(bQ.size() >= 17), 1);
        for (int i = 0; i < 17 && i < bQ.size(); i++)
            checkValue($sformatf("b_frame%0d", i), bQ[i], (i * 64) % 1024);

        // Mid-frame HACT change is deferred to the next frame.
        k = 0;
        while (k < 200 && !(o_hcnt == 9'd3 && o_vcnt == 9'd2)) begin applyStimulus(0, 1); k++; end
        checkValue("reach_h3v2", int'(o_hcnt == 9'd3 && o_vcnt == 9'd2), 1);
        i_HACT = 6'd8;
        clearTally();
        prevFd = 0; gotAfter = 0; hAfter = -1; vAfter = -1;
        repeat (200) begin
            applyStimulus(0, 1);
            if (prevFd && !gotAfter) begin hAfter = int'(o_hcnt); vAfter = int'(o_vcnt); gotAfter = 1; end
            prevFd = o_frame_done;
        end
        checkValue("hact8_period", (fdQ.size() >= 2) ? fdQ[1] - fdQ[0] : -1, 70);
        checkValue("no_gap_h", hAfter, 1);
        checkValue("no_gap_v", vAfter, 1);

        // Drop i_en at line 2; a re-assert while draining must be ignored.
        i_HACT = 6'd4;
        k = 0;
        while (k < 200 && !o_frame_done) begin applyStimulus(0, 1); k++; end
        k = 0;
        while (k < 200 && o_vcnt != 9'd2) begin applyStimulus(0, 1); k++; end
        checkValue("reach_v2", int'(o_vcnt), 2);
        repeat (5) applyStimulus(0, 0);
        repeat (5) applyStimulus(0, 1);
        fdV = -1; fdH = -1; k = 0;
        while (k < 200 && fdV < 0) begin
            applyStimulus(0, 0);
            if (o_frame_done) begin fdV = int'(o_vcnt); fdH = int'(o_hcnt); end
            k++;
        end
        checkValue("drain_fd_vcnt", fdV, 5);
        checkValue("drain_fd_hcnt", fdH, 10);
        repeat (3) applyStimulus(0, 0);
        checkValue("idle_hcnt", int'(o_hcnt), 0);
        checkValue("idle_de", int'(o_de), 0);

        // Rejected starts: one error pulse per attempt, no timing activity.
        setCfg(2, 3, 4, 1, 1, 1, 0, 1);
        clearTally();
        repeat (3) begin
            applyStimulus(0, 1);
            repeat (3) applyStimulus(0, 0);
        end
        checkValue("cfg_err_pulses", ceCnt, 3);
        checkValue("cfg_err_sync", hsCnt + vsCnt + deCnt, 0);

        // Reset mid-frame, then restart from the top.
        setCfg(2, 3, 4, 1, 1, 1, 2, 1);
        k = 0;
        while (k < 200 && !(o_hcnt == 9'd7 && o_vcnt == 9'd3)) begin applyStimulus(0, 1); k++; end
        checkValue("reach_h7v3", int'(o_hcnt == 9'd7 && o_vcnt == 9'd3), 1);
        applyStimulus(1, 1);
        checkValue("rst_hcnt", int'(o_hcnt), 0);
        checkValue("rst_fd", int'(o_frame_done), 0);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        checkValue("restart_h", int'(o_hcnt), 1);
        checkValue("restart_v", int'(o_vcnt), 1);

        // All porches zero: HTOT=4, VTOT=3.
        setCfg(1, 0, 3, 0, 1, 0, 2, 0);
        clearTally();
        repeat (100) applyStimulus(0, 1);
        checkValue("zero_porch_period", (fdQ.size() >= 2) ? fdQ[fdQ.size()-1] - fdQ[fdQ.size()-2] : -1, 12);

        // Random configs, enables and occasional resets against the model.
        en = 1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) randomCfg();
            if ($urandom_range(0, 39) == 0) en = !en;
            applyStimulus($urandom_range(0, 499) == 0, en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
